// File: rtl/cpu_defs.sv
// Shared LA32R front-end types: fetch bundle, IF-stage FSM encoding, widths.
// Combinational definitions only; no latency or backpressure of their own.
package cpu_defs;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h1C00_0000;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_bundle_t;

  typedef enum logic {
    IF_IDLE  = 1'b0,
    IF_FETCH = 1'b1
  } if_state_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: ROM request/response, redirect input and ID-facing valid/ready.
// master = fetch stage, slave = ROM/ID/branch environment; no timing of its own.
interface if_fetch_stage_if;
  import cpu_defs::*;

  logic              irom_req;
  logic [PC_W-1:0]   irom_addr;
  logic              irom_gnt;
  logic              irom_rvalid;
  logic [INST_W-1:0] irom_rdata;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              id_ready;
  logic              id_valid;
  logic [INST_W-1:0] id_inst;
  logic [PC_W-1:0]   id_pc;

  modport master (
    output irom_req, irom_addr, id_valid, id_inst, id_pc,
    input  irom_gnt, irom_rvalid, irom_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  irom_req, irom_addr, id_valid, id_inst, id_pc,
    output irom_gnt, irom_rvalid, irom_rdata, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/if_inst_queue.sv
// Instruction queue of {inst, pc}: push visible at head one cycle later, registered head.
// No internal backpressure; the caller bounds occupancy so push never meets a full queue.
module if_inst_queue
  import cpu_defs::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          cpu_clk,
  input  logic          cpu_rstn,
  input  logic          push,
  input  fetch_bundle_t push_dat,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] cnt,
  output fetch_bundle_t head
);

  fetch_bundle_t mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign cnt  = cnt_q;
  assign head = mem[rd_ptr];

  a_no_push_full: assert property (@(posedge cpu_clk) disable iff (!cpu_rstn)
    push |-> (cnt_q < CW'(DEPTH)));

endmodule

// File: rtl/if_fetch_stage.sv
// LA32R IF stage: in-order ROM fetch, grant->rvalid k cycles, id_valid one cycle after rvalid.
// id_ready low holds the queue head; requests stop once pend+drop+cnt reaches IQ_DEPTH.
module if_fetch_stage
  import cpu_defs::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              IQ_DEPTH = 2
) (
  input logic               cpu_clk,
  input logic               cpu_rstn,
  if_fetch_stage_if.master  bus
);

  localparam int CW = $clog2(IQ_DEPTH) + 1;
  localparam int OW = CW + 2;

  if_state_t       state_q;
  if_state_t       state_d;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] resp_pc;
  logic [CW-1:0]   pend;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   cnt;
  logic [OW-1:0]   occ;
  logic [CW-1:0]   drop_sum;
  logic [CW-1:0]   drop_redir;
  logic            req;
  logic            fire;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            id_vld;
  fetch_bundle_t   head;
  fetch_bundle_t   push_dat;

  // Occupancy counts every slot that a granted fetch may still land in.
  assign occ = OW'(pend) + OW'(drop) + OW'(cnt);

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      IF_IDLE:  state_d = IF_FETCH;
      IF_FETCH: req = !bus.redirect_valid && (occ < OW'(IQ_DEPTH));
    endcase
  end

  assign fire     = req && bus.irom_gnt;
  assign rsp_keep = bus.irom_rvalid && !bus.redirect_valid && (drop == '0) && (pend != '0);
  assign rsp_drop = bus.irom_rvalid && !bus.redirect_valid && (drop != '0);

  // Everything still in flight at a redirect becomes stale; a word arriving now is one of them.
  always_comb begin
    drop_sum   = drop + pend;
    drop_redir = drop_sum;
    if (bus.irom_rvalid && (drop_sum != '0)) drop_redir = drop_sum - 1'b1;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q  <= IF_IDLE;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      pend     <= '0;
      drop     <= '0;
    end else begin
      state_q <= state_d;
      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_pc & ~PC_W'(3);
        resp_pc  <= bus.redirect_pc & ~PC_W'(3);
        pend     <= '0;
        drop     <= drop_redir;
      end else begin
        if (fire)     fetch_pc <= fetch_pc + PC_W'(4);
        if (rsp_keep) resp_pc  <= resp_pc + PC_W'(4);
        pend <= pend + CW'(fire) - CW'(rsp_keep);
        if (rsp_drop) drop <= drop - 1'b1;
      end
    end
  end

  assign push_dat = '{inst: bus.irom_rdata, pc: resp_pc};
  assign id_vld   = (cnt != '0) && !bus.redirect_valid;

  if_inst_queue #(.DEPTH(IQ_DEPTH)) u_queue (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .push     (rsp_keep),
    .push_dat (push_dat),
    .pop      (id_vld && bus.id_ready),
    .flush    (bus.redirect_valid),
    .cnt      (cnt),
    .head     (head)
  );

  assign bus.irom_req  = req;
  assign bus.irom_addr = fetch_pc;
  assign bus.id_valid  = id_vld;
  assign bus.id_inst   = head.inst;
  assign bus.id_pc     = head.pc;

  a_rvalid_expected: assert property (@(posedge cpu_clk) disable iff (!cpu_rstn)
    bus.irom_rvalid |-> ((OW'(pend) + OW'(drop)) != '0));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with an in-order ROM model of programmable latency.
module tb_if_fetch_stage;
  import cpu_defs::*;

  localparam logic [31:0] RST_PC = 32'h1C00_0000;
  localparam logic [31:0] KEY    = 32'h5A5A_A5A5;
  localparam logic [31:0] TGT1   = 32'h1C00_0100;
  localparam logic [31:0] TGT2   = 32'h1C00_0200;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rom_ent_t;

  logic cpu_clk  = 1'b0;
  logic cpu_rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;
  int   rom_lat = 1;
  logic [31:0] exp_next;

  rom_ent_t      rom_q[$];
  logic [31:0]   grant_q[$];
  fetch_bundle_t got_q[$];

  if_fetch_stage_if bus();

  if_fetch_stage #(.RESET_PC(RST_PC), .IQ_DEPTH(2)) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .bus      (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  // ROM: responses in grant order, rom_lat cycles after grant; also logs grants and ID pops.
  always @(negedge cpu_clk) begin
    ncyc++;
    if (!cpu_rstn) begin
      rom_q.delete();
      bus.irom_rvalid = 1'b0;
      bus.irom_rdata  = '0;
    end else if (rom_q.size() != 0 && rom_q[0].due <= ncyc) begin
      bus.irom_rvalid = 1'b1;
      bus.irom_rdata  = rom_q[0].addr ^ KEY;
      void'(rom_q.pop_front());
    end else begin
      bus.irom_rvalid = 1'b0;
      bus.irom_rdata  = '0;
    end
    #1;
    if (cpu_rstn && bus.irom_req && bus.irom_gnt) begin
      rom_q.push_back('{addr: bus.irom_addr, due: ncyc + rom_lat});
      grant_q.push_back(bus.irom_addr);
    end
    if (cpu_rstn && bus.id_valid && bus.id_ready)
      got_q.push_back('{inst: bus.id_inst, pc: bus.id_pc});
  end

  task automatic step(input logic gnt, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge cpu_clk);
    bus.irom_gnt       = gnt;
    bus.id_ready       = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #2;
  endtask

  task automatic test_reset();
    cpu_rstn = 1'b0;
    repeat (3) step(1'b1, 1'b1, 1'b0, '0);
    checks++; if (bus.irom_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.irom_req); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b want 0", bus.id_valid); end
    checks++; if (bus.id_inst !== 32'h0) begin errors++; $display("FAIL reset_id_inst: got %h want 0", bus.id_inst); end
    checks++; if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc: got %h want 0", bus.id_pc); end
    checks++; if (bus.irom_addr !== RST_PC) begin errors++; $display("FAIL reset_addr: got %h want %h", bus.irom_addr, RST_PC); end
  endtask

  task automatic test_fetch_stream();
    int first_vld;
    first_vld = -1;
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    grant_q.delete();
    got_q.delete();
    #2;
    checks++; if (bus.irom_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", bus.irom_req); end
    for (int c = 1; c <= 14; c++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      if (c == 1) begin
        checks++; if (bus.irom_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", bus.irom_req); end
        checks++; if (bus.irom_addr !== RST_PC) begin errors++; $display("FAIL first_addr: got %h want %h", bus.irom_addr, RST_PC); end
      end
      if (bus.id_valid === 1'b1 && first_vld < 0) first_vld = c;
    end
    checks++; if (first_vld != 3) begin errors++; $display("FAIL first_id_valid_cycle: got %0d want 3", first_vld); end
    checks++; if (got_q.size() < 8) begin errors++; $display("FAIL stream_count: got %0d want >=8", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].pc !== RST_PC + 32'(4 * i) || got_q[i].inst !== ((RST_PC + 32'(4 * i)) ^ KEY)) begin
        errors++; $display("FAIL stream_id[%0d]: got pc %h inst %h want pc %h", i, got_q[i].pc, got_q[i].inst, RST_PC + 32'(4 * i));
      end
    end
    for (int i = 0; i < grant_q.size(); i++) begin
      checks++; if (grant_q[i] !== RST_PC + 32'(4 * i)) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", i, grant_q[i], RST_PC + 32'(4 * i)); end
    end
    exp_next = RST_PC + 32'(4 * got_q.size());
  endtask

  task automatic test_stall();
    got_q.delete();
    grant_q.delete();
    for (int c = 1; c <= 6; c++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      if (c >= 2) begin
        checks++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== exp_next) begin
          errors++; $display("FAIL stall_hold[%0d]: got vld %b pc %h want 1 %h", c, bus.id_valid, bus.id_pc, exp_next);
        end
      end
    end
    checks++; if (bus.irom_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b want 0", bus.irom_req); end
    checks++; if (grant_q.size() > 2) begin errors++; $display("FAIL stall_grants: got %0d want <=2", grant_q.size()); end
    repeat (8) step(1'b1, 1'b1, 1'b0, '0);
    checks++; if (got_q.size() < 4) begin errors++; $display("FAIL stall_resume_count: got %0d want >=4", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].pc !== exp_next + 32'(4 * i) || got_q[i].inst !== ((exp_next + 32'(4 * i)) ^ KEY)) begin
        errors++; $display("FAIL stall_resume[%0d]: got pc %h want %h", i, got_q[i].pc, exp_next + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect();
    repeat (5) step(1'b0, 1'b1, 1'b0, '0);
    rom_lat = 3;
    step(1'b1, 1'b1, 1'b0, '0);
    checks++; if (bus.irom_req !== 1'b1) begin errors++; $display("FAIL redir_req_a: got %b want 1", bus.irom_req); end
    step(1'b1, 1'b1, 1'b0, '0);
    checks++; if (bus.irom_req !== 1'b1) begin errors++; $display("FAIL redir_req_b: got %b want 1", bus.irom_req); end
    step(1'b1, 1'b1, 1'b1, TGT1);
    checks++; if (bus.irom_req !== 1'b0 || bus.id_valid !== 1'b0) begin
      errors++; $display("FAIL redir_cycle: got req %b vld %b want 0 0", bus.irom_req, bus.id_valid);
    end
    got_q.delete();
    grant_q.delete();
    repeat (10) step(1'b1, 1'b1, 1'b0, '0);
    checks++; if (got_q.size() < 2) begin errors++; $display("FAIL redir_count: got %0d want >=2", got_q.size()); end
    checks++; if (grant_q.size() == 0 || grant_q[0] !== TGT1) begin errors++; $display("FAIL redir_first_addr: got %h want %h", grant_q.size() ? grant_q[0] : 32'hx, TGT1); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].pc !== TGT1 + 32'(4 * i) || got_q[i].inst !== ((TGT1 + 32'(4 * i)) ^ KEY)) begin
        errors++; $display("FAIL redir_id[%0d]: got pc %h want %h", i, got_q[i].pc, TGT1 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_rvalid();
    rom_lat = 1;
    repeat (5) step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    checks++; if (bus.irom_req !== 1'b1) begin errors++; $display("FAIL rr_req: got %b want 1", bus.irom_req); end
    step(1'b0, 1'b1, 1'b1, TGT2);
    checks++; if (bus.irom_req !== 1'b0 || bus.id_valid !== 1'b0) begin
      errors++; $display("FAIL rr_cycle: got req %b vld %b want 0 0", bus.irom_req, bus.id_valid);
    end
    got_q.delete();
    step(1'b1, 1'b1, 1'b0, '0);
    checks++; if (bus.irom_req !== 1'b1 || bus.irom_addr !== TGT2) begin
      errors++; $display("FAIL rr_next_addr: got req %b addr %h want 1 %h", bus.irom_req, bus.irom_addr, TGT2);
    end
    repeat (5) step(1'b1, 1'b1, 1'b0, '0);
    checks++; if (got_q.size() == 0 || got_q[0].pc !== TGT2) begin errors++; $display("FAIL rr_first_pc: got %h want %h", got_q.size() ? got_q[0].pc : 32'hx, TGT2); end
  endtask

  task automatic test_misaligned_gnt_low();
    step(1'b0, 1'b1, 1'b1, 32'h1C00_0102);
    grant_q.delete();
    got_q.delete();
    for (int c = 1; c <= 5; c++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      checks++; if (bus.irom_addr !== TGT1) begin errors++; $display("FAIL gnt_low_addr[%0d]: got %h want %h", c, bus.irom_addr, TGT1); end
    end
    checks++; if (bus.irom_req !== 1'b1) begin errors++; $display("FAIL gnt_low_req: got %b want 1", bus.irom_req); end
    repeat (6) step(1'b1, 1'b1, 1'b0, '0);
    checks++; if (grant_q.size() == 0 || grant_q[0] !== TGT1) begin errors++; $display("FAIL align_grant: got %h want %h", grant_q.size() ? grant_q[0] : 32'hx, TGT1); end
    checks++; if (got_q.size() == 0 || got_q[0].pc !== TGT1) begin errors++; $display("FAIL align_pc: got %h want %h", got_q.size() ? got_q[0].pc : 32'hx, TGT1); end
  endtask

  task automatic test_reset_mid();
    repeat (4) step(1'b1, 1'b0, 1'b0, '0);
    checks++; if (bus.id_valid !== 1'b1 || bus.irom_req !== 1'b0) begin
      errors++; $display("FAIL full_before_rst: got vld %b req %b want 1 0", bus.id_valid, bus.irom_req);
    end
    @(negedge cpu_clk);
    cpu_rstn = 1'b0;
    #2;
    checks++; if (bus.id_valid !== 1'b0 || bus.irom_req !== 1'b0) begin
      errors++; $display("FAIL mid_rst_out: got vld %b req %b want 0 0", bus.id_valid, bus.irom_req);
    end
    checks++; if (bus.id_pc !== 32'h0 || bus.irom_addr !== RST_PC) begin
      errors++; $display("FAIL mid_rst_regs: got id_pc %h addr %h want 0 %h", bus.id_pc, bus.irom_addr, RST_PC);
    end
    repeat (2) step(1'b1, 1'b1, 1'b0, '0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    grant_q.delete();
    got_q.delete();
    #2;
    repeat (8) step(1'b1, 1'b1, 1'b0, '0);
    checks++; if (grant_q.size() == 0 || grant_q[0] !== RST_PC) begin errors++; $display("FAIL refetch_addr: got %h want %h", grant_q.size() ? grant_q[0] : 32'hx, RST_PC); end
    checks++; if (got_q.size() == 0 || got_q[0].pc !== RST_PC || got_q[0].inst !== (RST_PC ^ KEY)) begin
      errors++; $display("FAIL refetch_id: got pc %h want %h", got_q.size() ? got_q[0].pc : 32'hx, RST_PC);
    end
  endtask

  initial begin
    bus.irom_gnt       = 1'b0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.irom_rvalid    = 1'b0;
    bus.irom_rdata     = '0;
    test_reset();
    test_fetch_stream();
    test_stall();
    test_redirect();
    test_redirect_rvalid();
    test_misaligned_gnt_low();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
